// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode encodings, decode FSM states
// and immediate format selectors.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {IDLE, RDREG, VALID} dec_state_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; the 32-bit result is
// sign-extended to D_WIDTH.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [31:0]        instr,
  input  imm_type_t          imm_type,
  output logic [D_WIDTH-1:0] imm
);

  logic signed [31:0] imm32;
  logic               unused_opcode;

  // The opcode field never contributes to any immediate format.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = D_WIDTH'(imm32);

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage: accepts an instruction, reads both operands from the
// register file, then presents the decoded bundle to execute.
module instr_decode
  import riscv_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instrIn,
  input  logic [D_WIDTH-1:0] pcIn,
  input  logic               instrValid,
  output logic               instrReady,
  output logic [4:0]         rs1Addr,
  output logic [4:0]         rs2Addr,
  output logic               regLd,
  input  logic [D_WIDTH-1:0] rs1Dat,
  input  logic [D_WIDTH-1:0] rs2Dat,
  output logic               decValid,
  input  logic               decReady,
  output logic [6:0]         decOpcode,
  output logic [2:0]         decFunct3,
  output logic               decF7b5,
  output logic [4:0]         decRd,
  output logic [D_WIDTH-1:0] decImm,
  output logic [D_WIDTH-1:0] decRs1Val,
  output logic [D_WIDTH-1:0] decRs2Val,
  output logic [D_WIDTH-1:0] decPc,
  output logic               decRegWr,
  output logic               decMemRd,
  output logic               decMemWr,
  output logic               decBranch,
  output logic               decJump,
  output logic               decAluImm,
  output logic               decIllegal
);

  dec_state_t         state, state_nxt;
  logic [31:0]        instr_q;
  logic [D_WIDTH-1:0] pc_q;
  logic               load_instr, ready_c, reg_ld_c, dec_valid_c;

  logic [6:0]         opcode;
  logic               is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic               is_load, is_store, is_op_imm, is_op, is_legal;
  logic               uses_rs1, uses_rs2;
  imm_type_t          imm_type;
  logic [D_WIDTH-1:0] imm_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_instr) begin
      instr_q <= instrIn;
      pc_q    <= pcIn;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_instr  = 1'b0;
    ready_c     = 1'b0;
    reg_ld_c    = 1'b0;
    dec_valid_c = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (instrValid) begin
          load_instr = 1'b1;
          state_nxt  = RDREG;
        end
      end
      RDREG: begin
        reg_ld_c  = 1'b1;
        state_nxt = VALID;
      end
      VALID: begin
        // Register file holds its outputs while regLd is low, so the operands stay stable.
        dec_valid_c = 1'b1;
        ready_c     = decReady;
        if (decReady) begin
          if (instrValid) begin
            load_instr = 1'b1;
            state_nxt  = RDREG;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    opcode    = instr_q[6:0];
    is_lui    = (opcode == OPC_LUI);
    is_auipc  = (opcode == OPC_AUIPC);
    is_jal    = (opcode == OPC_JAL);
    is_jalr   = (opcode == OPC_JALR);
    is_branch = (opcode == OPC_BRANCH);
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_op_imm = (opcode == OPC_OP_IMM);
    is_op     = (opcode == OPC_OP);
    is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                is_load | is_store | is_op_imm | is_op;
    uses_rs1  = ~(is_lui | is_auipc | is_jal);
    uses_rs2  = is_branch | is_store | is_op;

    imm_type = IMM_NONE;
    if (is_lui | is_auipc)                 imm_type = IMM_U;
    else if (is_jal)                       imm_type = IMM_J;
    else if (is_jalr | is_load | is_op_imm) imm_type = IMM_I;
    else if (is_store)                     imm_type = IMM_S;
    else if (is_branch)                    imm_type = IMM_B;
  end

  imm_gen #(.D_WIDTH(D_WIDTH)) u_imm_gen (
    .instr    (instr_q),
    .imm_type (imm_type),
    .imm      (imm_raw)
  );

  // instrReady must read 0 while reset is held, even though the state already sits in IDLE.
  assign instrReady = ready_c & ~rst;
  assign regLd      = reg_ld_c;
  assign rs1Addr    = (reg_ld_c && uses_rs1) ? instr_q[19:15] : 5'd0;
  assign rs2Addr    = (reg_ld_c && uses_rs2) ? instr_q[24:20] : 5'd0;

  assign decValid   = dec_valid_c;
  assign decOpcode  = dec_valid_c ? opcode : 7'd0;
  assign decFunct3  = dec_valid_c ? instr_q[14:12] : 3'd0;
  assign decF7b5    = dec_valid_c & instr_q[30];
  assign decRd      = dec_valid_c ? instr_q[11:7] : 5'd0;
  assign decImm     = dec_valid_c ? imm_raw : '0;
  assign decRs1Val  = dec_valid_c ? rs1Dat : '0;
  assign decRs2Val  = dec_valid_c ? rs2Dat : '0;
  assign decPc      = dec_valid_c ? pc_q : '0;

  assign decRegWr   = dec_valid_c & (is_lui | is_auipc | is_jal | is_jalr | is_load |
                                     is_op_imm | is_op) & (instr_q[11:7] != 5'd0);
  assign decMemRd   = dec_valid_c & is_load;
  assign decMemWr   = dec_valid_c & is_store;
  assign decBranch  = dec_valid_c & is_branch;
  assign decJump    = dec_valid_c & (is_jal | is_jalr);
  assign decAluImm  = dec_valid_c & (is_op_imm | is_load | is_store | is_jalr | is_lui | is_auipc);
  assign decIllegal = dec_valid_c & ~is_legal;

endmodule

// File: tb/tb_instr_decode.sv
// Randomized bench for instr_decode with a register file model and a
// reference decoder derived from the RV32I encoding rules.
module tb_instr_decode;

  localparam int D_WIDTH = 32;
  localparam int N_TXN   = 40;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        instrIn;
  logic [D_WIDTH-1:0] pcIn;
  logic               instrValid, instrReady;
  logic [4:0]         rs1Addr, rs2Addr;
  logic               regLd;
  logic [D_WIDTH-1:0] rs1Dat = '0, rs2Dat = '0;
  logic               decValid, decReady;
  logic [6:0]         decOpcode;
  logic [2:0]         decFunct3;
  logic               decF7b5;
  logic [4:0]         decRd;
  logic [D_WIDTH-1:0] decImm, decRs1Val, decRs2Val, decPc;
  logic               decRegWr, decMemRd, decMemWr, decBranch, decJump, decAluImm, decIllegal;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] regs [32];

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [6:0]  flags;
  } exp_t;

  instr_decode #(.D_WIDTH(D_WIDTH)) dut (
    .clk(clk), .rst(rst), .instrIn(instrIn), .pcIn(pcIn),
    .instrValid(instrValid), .instrReady(instrReady),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .regLd(regLd),
    .rs1Dat(rs1Dat), .rs2Dat(rs2Dat),
    .decValid(decValid), .decReady(decReady),
    .decOpcode(decOpcode), .decFunct3(decFunct3), .decF7b5(decF7b5), .decRd(decRd),
    .decImm(decImm), .decRs1Val(decRs1Val), .decRs2Val(decRs2Val), .decPc(decPc),
    .decRegWr(decRegWr), .decMemRd(decMemRd), .decMemWr(decMemWr),
    .decBranch(decBranch), .decJump(decJump), .decAluImm(decAluImm), .decIllegal(decIllegal)
  );

  always #5 clk = ~clk;

  // Register file: outputs update only on regLd, x0 reads zero.
  always @(posedge clk) begin
    if (regLd) begin
      rs1Dat <= (rs1Addr == 5'd0) ? '0 : regs[rs1Addr];
      rs2Dat <= (rs2Addr == 5'd0) ? '0 : regs[rs2Addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    if (obs === expv) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, expv, $time);
  endtask

  function automatic exp_t refDecode(input logic [31:0] w);
    exp_t  e;
    string cls;
    int    s;
    logic  regWr, memRd, memWr, br, jmp, aluImm, ill;
    s = w;
    case (w[6:0])
      7'h37:   cls = "LUI";
      7'h17:   cls = "AUIPC";
      7'h6F:   cls = "JAL";
      7'h67:   cls = "JALR";
      7'h63:   cls = "BRANCH";
      7'h03:   cls = "LOAD";
      7'h23:   cls = "STORE";
      7'h13:   cls = "OPIMM";
      7'h33:   cls = "OP";
      default: cls = "ILL";
    endcase
    e.op   = w[6:0];
    e.f3   = w[14:12];
    e.f7b5 = w[30];
    e.rd   = w[11:7];
    if (cls == "LUI" || cls == "AUIPC")                       e.imm = w & 32'hFFFF_F000;
    else if (cls == "JAL")
      e.imm = (s >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    else if (cls == "JALR" || cls == "LOAD" || cls == "OPIMM") e.imm = s >>> 20;
    else if (cls == "STORE")  e.imm = (s >>> 25) * 32 + int'(w[11:7]);
    else if (cls == "BRANCH")
      e.imm = (s >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    else e.imm = 32'd0;
    e.rs1  = (cls == "LUI" || cls == "AUIPC" || cls == "JAL") ? 5'd0 : w[19:15];
    e.rs2  = (cls == "BRANCH" || cls == "STORE" || cls == "OP") ? w[24:20] : 5'd0;
    regWr  = (cls == "LUI" || cls == "AUIPC" || cls == "JAL" || cls == "JALR" ||
              cls == "LOAD" || cls == "OPIMM" || cls == "OP") && (w[11:7] != 5'd0);
    memRd  = (cls == "LOAD");
    memWr  = (cls == "STORE");
    br     = (cls == "BRANCH");
    jmp    = (cls == "JAL" || cls == "JALR");
    aluImm = (cls == "OPIMM" || cls == "LOAD" || cls == "STORE" || cls == "JALR" ||
              cls == "LUI" || cls == "AUIPC");
    ill    = (cls == "ILL");
    e.flags = {regWr, memRd, memWr, br, jmp, aluImm, ill};
    return e;
  endfunction

  function automatic logic [31:0] regVal(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : regs[a];
  endfunction

  logic [31:0] insList [N_TXN];
  logic [31:0] pcList  [N_TXN];
  int          holdFor [N_TXN];
  bit          chainFor[N_TXN];

  task automatic applyStimulus();
    logic [6:0] opcs [9];
    logic [31:0] w;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[1] = 32'd7;
    for (int i = 0; i < N_TXN; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) < 8) w[6:0] = opcs[$urandom_range(0, 8)];
      if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
      insList[i]  = w;
      pcList[i]   = $urandom & 32'hFFFF_FFFC;
      holdFor[i]  = $urandom_range(0, 3);
      chainFor[i] = (i < N_TXN - 1) && ($urandom_range(0, 1) == 1);
    end
    insList[0] = 32'hFFF08293;
    insList[1] = 32'h0021A423;
    holdFor[1] = 5;
    chainFor[1] = 1'b1;
    insList[2] = 32'h12345037;
    insList[3] = 32'h0000007F;
    insList[4] = 32'hFE000EE3;
    insList[5] = 32'h001000EF;
    chainFor[N_TXN-1] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] expR1, expR2;
    bit accepted;

    rst = 1'b1; instrValid = 1'b0; instrIn = '0; pcIn = '0; decReady = 1'b0;
    applyStimulus();
    #2;
    checkOutput("rst_instrReady", instrReady, 0);
    checkOutput("rst_decValid", decValid, 0);
    checkOutput("rst_regLd", regLd, 0);
    @(negedge clk); rst = 1'b0;

    accepted = 1'b0;
    for (int i = 0; i < N_TXN; i++) begin
      e = refDecode(insList[i]);
      if (!accepted) begin
        @(negedge clk);
        checkOutput("idle_instrReady", instrReady, 1);
        checkOutput("idle_decValid", decValid, 0);
        instrValid = 1'b1; instrIn = insList[i]; pcIn = pcList[i];
        @(posedge clk); #1;
        instrValid = 1'b0;
      end
      @(negedge clk);
      checkOutput("rd_regLd", regLd, 1);
      checkOutput("rd_rs1Addr", rs1Addr, e.rs1);
      checkOutput("rd_rs2Addr", rs2Addr, e.rs2);
      checkOutput("rd_instrReady", instrReady, 0);
      checkOutput("rd_decValid", decValid, 0);
      expR1 = regVal(e.rs1);
      expR2 = regVal(e.rs2);
      @(negedge clk);
      checkOutput("v_decValid", decValid, 1);
      checkOutput("v_regLd", regLd, 0);
      checkOutput("v_opcode", decOpcode, e.op);
      checkOutput("v_funct3", decFunct3, e.f3);
      checkOutput("v_f7b5", decF7b5, e.f7b5);
      checkOutput("v_rd", decRd, e.rd);
      checkOutput("v_imm", decImm, e.imm);
      checkOutput("v_rs1Val", decRs1Val, expR1);
      checkOutput("v_rs2Val", decRs2Val, expR2);
      checkOutput("v_pc", decPc, pcList[i]);
      checkOutput("v_flags", {decRegWr, decMemRd, decMemWr, decBranch, decJump, decAluImm, decIllegal},
                  e.flags);
      for (int h = 0; h < holdFor[i]; h++) begin
        instrValid = 1'b1; instrIn = $urandom;
        regs[$urandom_range(1, 31)] = $urandom;
        @(negedge clk);
        checkOutput("bp_decValid", decValid, 1);
        checkOutput("bp_instrReady", instrReady, 0);
        checkOutput("bp_imm", decImm, e.imm);
        checkOutput("bp_rs1Val", decRs1Val, expR1);
        checkOutput("bp_rs2Val", decRs2Val, expR2);
      end
      decReady = 1'b1;
      if (chainFor[i]) begin
        instrValid = 1'b1; instrIn = insList[i+1]; pcIn = pcList[i+1];
      end else begin
        instrValid = 1'b0;
      end
      #1;
      checkOutput("rel_instrReady", instrReady, 1);
      @(posedge clk); #1;
      decReady = 1'b0; instrValid = 1'b0;
      accepted = chainFor[i];
    end

    // Reset while a bundle is pending in VALID.
    @(negedge clk);
    instrValid = 1'b1; instrIn = 32'hFFF08293; pcIn = 32'h100;
    @(posedge clk); #1;
    instrValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_rst_decValid", decValid, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_decValid", decValid, 0);
    checkOutput("midrst_regLd", regLd, 0);
    checkOutput("midrst_instrReady", instrReady, 0);
    checkOutput("midrst_decImm", decImm, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_instrReady", instrReady, 1);
    checkOutput("post_rst_decValid", decValid, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
